// File: rtl/book_mem_arbiter.sv
// book_mem_arbiter: round-robin arbiter sharing one memory_manager (order-book BRAM) among NUM_REQ requesters.
//   clk_in, rst_n        : clock, asynchronous active-low reset
//   req_i/req_write_i    : per-requester request level and write flag
//   req_addr_i/req_data_i: packed per-requester address and write data (slice k = requester k)
//   ack_o/err_o          : one-hot completion pulse, timeout flag alongside it
//   rd_data_o            : last read data, valid with ack_o on a successful read
//   busy_o               : high whenever an access is in progress
//   mm_*                 : start/is_write/addr/data handshake to and from memory_manager
module book_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int ENTRY_W = 64,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ*ENTRY_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       err_o,
    output logic [ENTRY_W-1:0]         rd_data_o,
    output logic                       busy_o,
    output logic                       mm_start_o,
    output logic                       mm_is_write_o,
    output logic [ADDR_W-1:0]          mm_addr_o,
    output logic [ENTRY_W-1:0]         mm_data_o,
    input  logic [ENTRY_W-1:0]         mm_data_i,
    input  logic                       mm_valid_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               is_write_q, is_write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ENTRY_W-1:0] data_q, data_d;
    logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
    logic               err_q, err_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic               gnt_found;
    logic [IW-1:0]      gnt_idx;
    logic [IW:0]        gnt_sum;

    // Scan offsets from farthest to nearest so the nearest set request after rr_ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_sum   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            gnt_sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (gnt_sum >= (IW+1)'(NUM_REQ)) gnt_sum = gnt_sum - (IW+1)'(NUM_REQ);
            if (req_i[gnt_sum[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = gnt_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        timer_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    is_write_d = req_write_i[gnt_idx];
                    addr_d     = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
                    data_d     = req_data_i[gnt_idx*ENTRY_W +: ENTRY_W];
                    rr_ptr_d   = gnt_idx;
                    state_d    = S_ISSUE;
                end
            end
            // Timer reads 0 during ISSUE and k during the k-th WAIT cycle, so a timeout
            // ack lands exactly TIMEOUT cycles after the start pulse.
            S_ISSUE: begin
                timer_d = TW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (mm_valid_i) begin
                    if (!is_write_q) rd_data_d = mm_data_i;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    assign ack_o         = (state_q == S_DONE) ? NUM_REQ'(1) << rr_ptr_q : '0;
    assign err_o         = (state_q == S_DONE) && err_q;
    assign rd_data_o     = rd_data_q;
    assign busy_o        = (state_q != S_IDLE);
    assign mm_start_o    = (state_q == S_ISSUE);
    assign mm_is_write_o = is_write_q;
    assign mm_addr_o     = addr_q;
    assign mm_data_o     = data_q;
endmodule

// File: doc/book_mem_arbiter.md
Name: book_mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one memory_manager instance (order-book BRAM) among NUM_REQ requesters, e.g. order-entry, matching and cancel engines.
- Grants one request at a time and drives the memory_manager start/is_write/addr/data_i handshake.
- Waits for its valid pulse, returns read data and a per-requester ack, and aborts with an error if valid never arrives.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, ADDRESS_INDEX+1, BRAM address width.
- ENTRY_W, $bits(book_entry), book entry width.
- TIMEOUT, 16, max cycles from start to valid before abort; must exceed BRAM_LATENCY+2.

Ports:
- clk_in  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request level; held high until that requester's ack.
- req_write_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k uses slice k.
- req_data_i  in  NUM_REQ*ENTRY_W  packed write data.
- ack_o  out  NUM_REQ  one-hot, one-cycle completion pulse.
- err_o  out  1  high with ack_o when the access timed out.
- rd_data_o  out  ENTRY_W  last read data; valid with ack_o on a successful read.
- busy_o  out  1  high in any state except IDLE.
- mm_start_o  out  1  to memory_manager start.
- mm_is_write_o  out  1  to memory_manager is_write.
- mm_addr_o  out  ADDR_W  to memory_manager addr.
- mm_data_o  out  ENTRY_W  to memory_manager data_i.
- mm_data_i  in  ENTRY_W  from memory_manager data_o.
- mm_valid_i  in  1  from memory_manager valid (one-cycle pulse).

Behaviour:
- Reset (async, rst_n low): state = IDLE, all outputs 0, rr_ptr = NUM_REQ-1 so requester 0 has first priority, timer = 0. rst_n must be held low at least BRAM_LATENCY+2 cycles so an in-flight memory_manager access drains.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_i is set, grant the first set bit searching from rr_ptr+1 upward, with modulo NUM_REQ wrap.
  - On grant: latch the winner's write/addr/data into mm_is_write_o/mm_addr_o/mm_data_o, set rr_ptr = winner, go to ISSUE.
  - A stray mm_valid_i seen in IDLE is ignored.
- ISSUE: mm_start_o = 1 for exactly this one cycle; timer = 0; go to WAIT.
- WAIT:
  - mm_is_write_o, mm_addr_o and mm_data_o are held stable.
  - timer increments each cycle.
  - If mm_valid_i: when the access is a read, capture mm_data_i into rd_data_o; go to DONE with err = 0.
  - Else if timer == TIMEOUT-1: go to DONE with err = 1; rd_data_o is unchanged.
  - If mm_valid_i and timeout coincide, valid wins (err = 0).
- DONE:
  - ack_o[winner] = 1 and err_o = err for this one cycle; req_i is not sampled.
  - Requester must drop req_i at the clock edge ending the ack cycle, or raise it again for a new access.
  - Go to IDLE.
- Writes never modify rd_data_o.
- Latency, with req seen in IDLE at cycle 0:
  - mm_start_o at cycle 1.
  - mm_valid_i expected at cycle BRAM_LATENCY+2.
  - ack_o one cycle after mm_valid_i.
  - Minimum request-to-request spacing for back-to-back grants = access time + 2 cycles (DONE + IDLE).
- Fairness: after a grant to k, k has the lowest priority. With all requests continuously held, grants rotate 0,1,2,0,...
- Requests that drop before their grant are not remembered. Changes on req_*_i after grant have no effect on the current access.
- busy_o = (state != IDLE).

Test Plan:
- Single read: after reset, req_i=001, addr=5, write=0, memory returns 0xABCD -> mm_start_o pulses at cycle 1 with mm_addr_o=5; ack_o=001 one cycle after valid; rd_data_o=0xABCD; err_o=0.
- Write then read: req 1 writes 0x1234 to addr 9, then reads addr 9 -> first ack has rd_data_o unchanged and mm_is_write_o=1 during WAIT; second ack returns 0x1234.
- Round-robin: req_i=111 held (each requester re-requests after its ack) -> grant order 0,1,2,0,1,2; no requester is granted twice in a row while others are pending.
- Wrap/priority: rr_ptr=2 with req_i=110 -> grant 1; then rr_ptr=1 with req_i=101 -> grant 2.
- Timeout: mm_valid_i held 0 -> ack_o pulses with err_o=1 exactly TIMEOUT cycles after mm_start_o; rd_data_o unchanged; next request is served normally. Also check valid arriving in the final timeout cycle gives err_o=0.
- Reset mid-WAIT: assert rst_n low during WAIT -> all outputs 0 immediately; after release, the held req_i=001 is granted afresh and a stray valid during reset or IDLE produces no ack.
